// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//
// Control half of an SPI mode-0 (CPOL=0, CPHA=0) slave. The pins arrive
// asynchronously to clk and are brought into the clk domain here. This block
// owns the frame FSM, receive path, one-entry transmit buffer and error
// strobes. The MISO shift register lives outside this block and is driven
// by tx_word, cs_n, cs_n_negedge and shift_en.
//
// Parameters
//   DATA_WIDTH   word length in bits (2..32)
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, cs_n_in     raw SPI clock / chip-select pins (asynchronous)
//   mosi              raw SPI master-out data pin (asynchronous)
//   tx_data/tx_valid  next word to transmit, with its valid
//   tx_ready          transmit buffer empty, a word can be accepted
//   tx_word           word presented to the MISO shifter's data_in
//   cs_n              synchronized chip-select (to the MISO shifter)
//   cs_n_negedge      1-clk pulse when a frame starts (FSM in LOAD)
//   shift_en          1-clk pulse per qualified sclk falling edge
//   rx_data/rx_valid  last complete received word (MSB first) + update pulse
//   underrun          1-clk pulse: frame started with an empty tx buffer
//   frame_err         1-clk pulse: chip-select released mid-word
//   busy              FSM not in IDLE
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n_in,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_word,
  output logic                  cs_n,
  output logic                  cs_n_negedge,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                 CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. Index 0 is the metastability-catching flop, index 1 is
  // the synchronized level, index 2 (sclk/cs only) is the previous level for
  // edge detection. Registering the resulting strobes gives pin-to-pulse
  // latency of 3 clk. mosi travels through the same two stages as sclk so the
  // data bit stays aligned with its rising edge.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  // NOTE: state in clocked blocks is always assigned with <=, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;   // chip-select idles deasserted
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n_in};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_high;
  logic mosi_s;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_high   = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_n      = cs_sync[1];

  // ---------------------------------------------------------------------------
  // Frame FSM and event strobes
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic               rx_capture;   // last bit shifted in; copy to rx_data next

  logic shift_bit;
  logic rx_capture_d;
  logic shift_en_d;
  logic frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    shift_bit    = 1'b0;
    rx_capture_d = 1'b0;
    shift_en_d   = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        // Leaving on the synchronized level rather than the edge also catches
        // a chip-select that rose while the FSM was still passing through
        // LOAD; in the normal case the two coincide.
        if (cs_high) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt != CNT_FULL);
        end else begin
          // Once the word is complete further sclk edges are ignored until
          // the next frame.
          if (sclk_rise && (bit_cnt != CNT_FULL)) begin
            shift_bit    = 1'b1;
            rx_capture_d = (bit_cnt == CNT_LAST);
          end
          // The MISO shifter presents bit 0 on the LOAD cycle itself, so only
          // the falling edges after bits 1..DATA_WIDTH-1 advance it.
          if (sclk_fall && (bit_cnt != '0) && (bit_cnt != CNT_FULL)) begin
            shift_en_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_capture <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      shift_en   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_capture <= rx_capture_d;
      rx_valid   <= rx_capture;
      shift_en   <= shift_en_d;
      frame_err  <= frame_err_d;

      if (state_q == LOAD) begin
        bit_cnt <= '0;
      end else if (shift_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_bit) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
      end

      if (rx_capture) begin
        rx_data <= rx_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry transmit buffer. It is consumed in the LOAD cycle; a tx_valid
  // arriving in that same cycle refills it, so the buffer stays full.
  // ---------------------------------------------------------------------------
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  consume;
  logic                  load;

  assign consume = (state_q == LOAD);
  assign load    = tx_valid && (!buf_full || consume);

  // NOTE: the buffer word is reset along with its full flag even though
  // tx_word is already gated by buf_full; it costs one reset net and keeps
  // the register contents deterministic in simulation and on silicon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (load) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end else if (consume) begin
      buf_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. cs_n_negedge is exactly the single LOAD cycle, so tx_word is
  // guaranteed stable while the MISO shifter samples it.
  // ---------------------------------------------------------------------------
  assign tx_ready     = ~buf_full;
  assign tx_word      = buf_full ? buf_data : '0;
  assign cs_n_negedge = (state_q == LOAD);
  assign underrun     = (state_q == LOAD) && !buf_full;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//
// Directed bench for spi_slave_ctrl (DATA_WIDTH = 8). A table of whole frames
// is applied in a loop; separate sequences cover a tx write coinciding with
// buffer consumption and a reset in the middle of a frame. A monitor counts
// output pulses at the falling clk edge; frame results are the difference of
// those counts taken before and after each frame.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

  localparam int W     = 8;
  localparam int HALF  = 4;      // sclk half period, in clk cycles

  logic         clk;
  logic         rst_n;
  logic         sclk;
  logic         cs_n_in;
  logic         mosi;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_word;
  logic         cs_n;
  logic         cs_n_negedge;
  logic         shift_en;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         underrun;
  logic         frame_err;
  logic         busy;

  spi_slave_ctrl #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs_n_in      (cs_n_in),
    .mosi         (mosi),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_word      (tx_word),
    .cs_n         (cs_n),
    .cs_n_negedge (cs_n_negedge),
    .shift_en     (shift_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .underrun     (underrun),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Pulse monitor
  // ---------------------------------------------------------------------------
  int         m_neg, m_shift, m_rxv, m_ferr, m_under, m_under_stray;
  logic [W-1:0] m_neg_word;

  initial begin
    m_neg = 0; m_shift = 0; m_rxv = 0; m_ferr = 0; m_under = 0;
    m_under_stray = 0; m_neg_word = '0;
  end

  always @(negedge clk) begin
    if (cs_n_negedge) begin
      m_neg      <= m_neg + 1;
      m_neg_word <= tx_word;
    end
    if (shift_en)  m_shift <= m_shift + 1;
    if (rx_valid)  m_rxv   <= m_rxv + 1;
    if (frame_err) m_ferr  <= m_ferr + 1;
    if (underrun)  m_under <= m_under + 1;
    if (underrun && !cs_n_negedge) m_under_stray <= m_under_stray + 1;
  end

  int s_neg, s_shift, s_rxv, s_ferr, s_under;

  task automatic snap();
    s_neg = m_neg; s_shift = m_shift; s_rxv = m_rxv;
    s_ferr = m_ferr; s_under = m_under;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    wait_clk(1);
  endtask

  // n sclk cycles, mosi MSB first; bits past the word are sent as 0.
  task automatic send_bits(input logic [W-1:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = (i < W) ? word[W-1-i] : 1'b0;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
  endtask

  task automatic run_frame(input logic [W-1:0] word, input int n);
    cs_n_in = 1'b0;
    wait_clk(6);
    send_bits(word, n);
    cs_n_in = 1'b1;
    wait_clk(10);
  endtask

  // ---------------------------------------------------------------------------
  // Frame vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string        name;
    logic         do_load;
    logic [W-1:0] load_word;
    logic [W-1:0] mosi_word;
    int           n_sclk;
    logic [W-1:0] exp_tx_word;
    int           exp_under;
    int           exp_shift;
    int           exp_rxv;
    int           exp_ferr;
    logic [W-1:0] exp_rx_data;
  } frame_vec_t;

  localparam int NVEC = 6;
  frame_vec_t vec [NVEC];

  initial begin
    // name        load  word   mosi  sclk  tx_word und sh rxv ferr rx_data
    vec[0] = '{"basic",     1'b1, 8'hA5, 8'h3C, 8,  8'hA5, 0, 7, 1, 0, 8'h3C};
    vec[1] = '{"underrun",  1'b0, 8'h00, 8'hC3, 8,  8'h00, 1, 7, 1, 0, 8'hC3};
    vec[2] = '{"short5",    1'b1, 8'h11, 8'hFF, 5,  8'h11, 0, 5, 0, 1, 8'hC3};
    vec[3] = '{"long12",    1'b1, 8'h81, 8'h96, 12, 8'h81, 0, 7, 1, 0, 8'h96};
    vec[4] = '{"no_sclk",   1'b1, 8'h24, 8'h00, 0,  8'h24, 0, 0, 0, 1, 8'h96};
    vec[5] = '{"ones",      1'b1, 8'h7E, 8'h01, 8,  8'h7E, 0, 7, 1, 0, 8'h01};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    logic got;
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sclk     = 1'b0;
    cs_n_in  = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;

    // Reset state
    wait_clk(3);
    check("rst_busy",      busy,         0);
    check("rst_tx_ready",  tx_ready,     1);
    check("rst_tx_word",   tx_word,      0);
    check("rst_rx_data",   rx_data,      0);
    check("rst_cs_n",      cs_n,         1);
    check("rst_pulses",    {cs_n_negedge, shift_en, rx_valid, underrun, frame_err}, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Table-driven frames
    for (int v = 0; v < NVEC; v++) begin
      if (vec[v].do_load) begin
        check({vec[v].name, "_ready_pre"}, tx_ready, 1);
        load_tx(vec[v].load_word);
        check({vec[v].name, "_ready_full"}, tx_ready, 0);
      end
      snap();
      run_frame(vec[v].mosi_word, vec[v].n_sclk);
      check({vec[v].name, "_negedge"},  m_neg - s_neg,     1);
      check({vec[v].name, "_tx_word"},  m_neg_word,        vec[v].exp_tx_word);
      check({vec[v].name, "_underrun"}, m_under - s_under, vec[v].exp_under);
      check({vec[v].name, "_shift_en"}, m_shift - s_shift, vec[v].exp_shift);
      check({vec[v].name, "_rx_valid"}, m_rxv - s_rxv,     vec[v].exp_rxv);
      check({vec[v].name, "_frame_err"},m_ferr - s_ferr,   vec[v].exp_ferr);
      check({vec[v].name, "_rx_data"},  rx_data,           vec[v].exp_rx_data);
      check({vec[v].name, "_ready_post"}, tx_ready,        1);
      check({vec[v].name, "_busy_post"},  busy,            0);
    end

    // tx_valid coinciding with consumption
    load_tx(8'hA5);
    snap();
    cs_n_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (cs_n_negedge) begin
        got = 1'b1;
        break;
      end
    end
    check("co_negedge_seen", got, 1);
    check("co_tx_word_a5", tx_word, 8'hA5);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    check("co_ready_full", tx_ready, 0);
    check("co_tx_word_5a", tx_word, 8'h5A);
    check("co_cs_n_low",   cs_n,    0);
    wait_clk(3);
    send_bits(8'h69, 8);
    cs_n_in = 1'b1;
    wait_clk(10);
    check("co_rx_data",  rx_data,       8'h69);
    check("co_rx_valid", m_rxv - s_rxv, 1);
    check("co_under",    m_under - s_under, 0);
    snap();
    run_frame(8'h00, 8);
    check("co_next_word", m_neg_word, 8'h5A);
    check("co_next_ready", tx_ready, 1);
    check("co_next_rx",  rx_data, 8'h00);

    // Reset in the middle of a frame
    load_tx(8'h33);
    snap();
    cs_n_in = 1'b0;
    wait_clk(6);
    send_bits(8'hF0, 4);
    check("mr_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_busy",     busy,     0);
    check("mr_tx_ready", tx_ready, 1);
    check("mr_tx_word",  tx_word,  0);
    check("mr_rx_data",  rx_data,  0);
    check("mr_pulses",   {cs_n_negedge, shift_en, rx_valid, underrun, frame_err}, 0);
    cs_n_in = 1'b1;
    sclk    = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);
    check("mr_no_rxv",  m_rxv - s_rxv,   0);
    check("mr_no_ferr", m_ferr - s_ferr, 0);
    check("mr_idle",    busy,            0);
    load_tx(8'h42);
    snap();
    run_frame(8'hA7, 8);
    check("mr_next_word",  m_neg_word,        8'h42);
    check("mr_next_rx",    rx_data,           8'hA7);
    check("mr_next_rxv",   m_rxv - s_rxv,     1);
    check("mr_next_shift", m_shift - s_shift, 7);
    check("mr_next_ferr",  m_ferr - s_ferr,   0);

    check("stray_underrun", m_under_stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
